// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module  : prog_mem_loader
//  Brief   : Instruction-fetch responder with a byte-stream program loader
//            that holds the core in reset while the image is written.
//  Rev     : 1.0  initial release
// ============================================================================
module prog_mem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_mem_prog_i,
    output logic [DATA_WIDTH-1:0] val_mem_prog_o,
    input  logic                  load_start_i,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_byte_i,
    input  logic                  load_last_i,
    output logic                  load_ready_o,
    output logic                  core_hold_o,
    output logic                  load_done_o,
    output logic [ADDR_WIDTH-2:0] word_count_o,
    output logic                  overflow_o
);

    localparam int                  c_DEPTH_INT = 2 ** (ADDR_WIDTH - 2);
    localparam logic [ADDR_WIDTH-2:0] c_DEPTH   = (ADDR_WIDTH-1)'(c_DEPTH_INT);
    localparam logic [ADDR_WIDTH-2:0] c_PTR_ONE = (ADDR_WIDTH-1)'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-2:0] r_ptr;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_asm;
    logic                  r_core_hold;
    logic                  r_load_done;
    logic                  r_overflow;
    logic [31:0]           r_mem [c_DEPTH_INT];

    logic                  w_accept;
    logic                  w_word_done;
    logic                  w_full;
    logic                  w_mem_we;
    logic [31:0]           w_word_data;
    logic                  w_unused_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        load_ready_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start_i) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                load_ready_o = 1'b1;
                if (!load_start_i && load_valid_i && load_last_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A restart request wins over a byte offered in the same cycle.
    assign w_accept    = load_valid_i && load_ready_o && !load_start_i;
    assign w_word_done = (r_byte_cnt == 2'd3) || load_last_i;
    assign w_full      = (r_ptr == c_DEPTH);
    assign w_mem_we    = w_accept && w_word_done && !w_full;

    // Lanes above the current byte are still zero because r_asm is cleared per word.
    assign w_word_data = {8'h00, r_asm} | (32'(load_byte_i) << {r_byte_cnt, 3'b000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_byte_cnt  <= 2'd0;
            r_asm       <= 24'h0;
            r_core_hold <= 1'b0;
            r_load_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (load_start_i) begin
            r_ptr       <= '0;
            r_byte_cnt  <= 2'd0;
            r_asm       <= 24'h0;
            r_core_hold <= 1'b1;
            r_load_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            if (w_accept) begin
                if (w_word_done) begin
                    r_byte_cnt <= 2'd0;
                    r_asm      <= 24'h0;
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + c_PTR_ONE;
                    end
                end else begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_asm      <= w_word_data[23:0];
                end
                if (load_last_i) begin
                    r_core_hold <= 1'b0;
                    r_load_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_ptr[ADDR_WIDTH-3:0]] <= w_word_data;
        end
    end

    assign w_unused_addr  = ^addr_mem_prog_i[1:0];
    assign val_mem_prog_o = (r_state == S_LOAD) ? DATA_WIDTH'(NOP_WORD)
                                                : DATA_WIDTH'(r_mem[addr_mem_prog_i[ADDR_WIDTH-1:2]]);
    assign core_hold_o    = r_core_hold;
    assign load_done_o    = r_load_done;
    assign word_count_o   = r_ptr;
    assign overflow_o     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_prog_mem_loader
//  Brief   : Directed bench for prog_mem_loader (default and 4-word instances).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_byte = 8'h00;
    logic       load_last = 1'b0;
    logic [9:0] addr_a = '0;
    logic [3:0] addr_s = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] val_a, val_s;
    logic        ready_a, hold_a, done_a, ovf_a;
    logic        ready_s, hold_s, done_s, ovf_s;
    logic [8:0]  wc_a;
    logic [2:0]  wc_s;

    always #5 clk = ~clk;

    prog_mem_loader u_dut_a (
        .clk             (clk),
        .rst             (rst),
        .addr_mem_prog_i (addr_a),
        .val_mem_prog_o  (val_a),
        .load_start_i    (load_start & ~sel),
        .load_valid_i    (load_valid & ~sel),
        .load_byte_i     (load_byte),
        .load_last_i     (load_last),
        .load_ready_o    (ready_a),
        .core_hold_o     (hold_a),
        .load_done_o     (done_a),
        .word_count_o    (wc_a),
        .overflow_o      (ovf_a)
    );

    prog_mem_loader #(.ADDR_WIDTH(4)) u_dut_s (
        .clk             (clk),
        .rst             (rst),
        .addr_mem_prog_i (addr_s),
        .val_mem_prog_o  (val_s),
        .load_start_i    (load_start & sel),
        .load_valid_i    (load_valid & sel),
        .load_byte_i     (load_byte),
        .load_last_i     (load_last),
        .load_ready_o    (ready_s),
        .core_hold_o     (hold_s),
        .load_done_o     (done_s),
        .word_count_o    (wc_s),
        .overflow_o      (ovf_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch_a(input logic [9:0] a, input string tag, input logic [31:0] exp);
        addr_a = a;
        #1;
        check(tag, val_a, exp);
    endtask

    task automatic fetch_s(input logic [3:0] a, input string tag, input logic [31:0] exp);
        addr_s = a;
        #1;
        check(tag, val_s, exp);
    endtask

    initial begin
        logic [7:0] img [8];
        img = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};

        // Reset
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_hold", hold_a, 0);
        check("rst_done", done_a, 0);
        check("rst_wc", wc_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_ovf", ovf_a, 0);

        // Basic load
        start();
        check("load_hold", hold_a, 1);
        check("load_ready", ready_a, 1);
        fetch_a(10'd0, "load_nop", 32'h0000_0013);
        for (int i = 0; i < 8; i++) begin
            send(img[i], i == 7);
            if (i == 3) check("mid_wc", wc_a, 1);
        end
        check("basic_done", done_a, 1);
        check("basic_hold", hold_a, 0);
        check("basic_wc", wc_a, 2);
        check("basic_ready", ready_a, 0);
        tick();
        check("basic_done_pulse", done_a, 0);
        fetch_a(10'd0, "basic_m0", 32'h0050_0013);
        fetch_a(10'd4, "basic_m1", 32'h00A0_0093);
        fetch_a(10'd7, "basic_lowbits", 32'h00A0_0093);

        // Partial word
        start();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        check("part_wc", wc_a, 1);
        check("part_done", done_a, 1);
        fetch_a(10'd0, "part_m0", 32'h00CC_BBAA);
        fetch_a(10'd4, "part_m1", 32'h00A0_0093);

        // Load with 3-cycle gaps restores the basic image
        start();
        for (int i = 0; i < 8; i++) begin
            send(img[i], i == 7);
            if (i != 7) begin
                repeat (3) tick();
                check("gap_hold", hold_a, 1);
            end
        end
        check("gap_wc", wc_a, 2);
        check("gap_done", done_a, 1);
        fetch_a(10'd0, "gap_m0", 32'h0050_0013);
        fetch_a(10'd4, "gap_m1", 32'h00A0_0093);

        // Restart mid-load; the byte offered alongside the restart is dropped
        start();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'hEE;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        check("restart_wc", wc_a, 0);
        check("restart_hold", hold_a, 1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        check("restart_wc_end", wc_a, 1);
        fetch_a(10'd0, "restart_m0", 32'h0403_0201);

        // Reset after 6 bytes
        start();
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mrst_hold", hold_a, 0);
        check("mrst_ready", ready_a, 0);
        tick();
        rst = 1'b0;
        check("mrst_done0", done_a, 0);
        tick();
        check("mrst_done1", done_a, 0);
        check("mrst_wc", wc_a, 0);
        fetch_a(10'd0, "mrst_m0", 32'hA4A3_A2A1);
        fetch_a(10'd4, "mrst_m1", 32'h00A0_0093);

        // Overflow on the 4-word instance
        sel = 1'b1;
        start();
        check("ovf_hold_s", hold_s, 1);
        check("ovf_other_idle", hold_a, 0);
        for (int w = 0; w < 5; w++) begin
            for (int b = 0; b < 4; b++) begin
                send(8'((w + 1) * 16 + b + 1), (w == 4) && (b == 3));
            end
            if (w == 3) begin
                check("ovf_wc4", wc_s, 4);
                check("ovf_not_yet", ovf_s, 0);
            end
        end
        check("ovf_flag", ovf_s, 1);
        check("ovf_wc_sat", wc_s, 4);
        check("ovf_done", done_s, 1);
        fetch_s(4'd0, "ovf_m0", 32'h1413_1211);
        fetch_s(4'd4, "ovf_m1", 32'h2423_2221);
        fetch_s(4'd8, "ovf_m2", 32'h3433_3231);
        fetch_s(4'd12, "ovf_m3", 32'h4443_4241);
        tick();
        check("ovf_sticky", ovf_s, 1);
        start();
        check("ovf_cleared", ovf_s, 0);
        check("ovf_wc_cleared", wc_s, 0);
        send(8'h77, 1'b1);
        check("ovf_end_wc", wc_s, 1);
        fetch_s(4'd0, "ovf_reload_m0", 32'h0000_0077);
        sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
